// File: rtl/dmem_master.sv
// Load/store initiator between the memory-access stage and a synchronous-write,
// combinational-read data RAM; owns lane steering, load extension and the LL/SC link bit.
module dmem_master #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        llbit_clr,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_excp,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    output logic [3:0]  ram_sel_o,
    input  logic [31:0] ram_data_i,
    output logic        llbit_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;
    localparam logic [3:0] OP_LL  = 4'd8;
    localparam logic [3:0] OP_SC  = 4'd9;

    state_t      r_state;
    logic [3:0]  r_op;
    logic [1:0]  r_off;
    logic        r_llbit;
    logic        r_ready;
    logic        r_respValid;
    logic [31:0] r_respRdata;
    logic        r_respExcp;
    logic        r_ce;
    logic        r_we;
    logic [31:0] r_ramAddr;
    logic [31:0] r_ramData;
    logic [3:0]  r_sel;

    logic        w_isByte;
    logic        w_isHalf;
    logic        w_isWord;
    logic        w_isStore;
    logic        w_misal;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;
    logic [1:0]  w_byteLane;
    logic [7:0]  w_loadByte;
    logic [15:0] w_loadHalf;
    logic [31:0] w_loadData;

    // Decode of the incoming request, used only at acceptance time.
    always_comb begin
        w_isByte  = (req_op == OP_LB) || (req_op == OP_LBU) || (req_op == OP_SB);
        w_isHalf  = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
        w_isWord  = (req_op == OP_LW) || (req_op == OP_SW) || (req_op == OP_LL) || (req_op == OP_SC);
        w_isStore = (req_op == OP_SB) || (req_op == OP_SH) || (req_op == OP_SW) || (req_op == OP_SC);
        w_misal   = (w_isHalf && req_addr[0]) || (w_isWord && (req_addr[1:0] != 2'b00));
        w_sel     = 4'b0000;
        if (w_isByte) begin
            w_sel = BIG_ENDIAN ? (4'b1000 >> req_addr[1:0]) : (4'b0001 << req_addr[1:0]);
        end else if (w_isHalf) begin
            w_sel = (req_addr[1] ^ BIG_ENDIAN) ? 4'b1100 : 4'b0011;
        end else if (w_isWord) begin
            w_sel = 4'b1111;
        end
        if (req_op == OP_SB) begin
            w_wdata = {4{req_wdata[7:0]}};
        end else if (req_op == OP_SH) begin
            w_wdata = {2{req_wdata[15:0]}};
        end else begin
            w_wdata = req_wdata;
        end
    end

    // Lane extraction of the RAM read data for the access being completed.
    always_comb begin
        w_byteLane = BIG_ENDIAN ? (2'd3 - r_off) : r_off;
        w_loadByte = ram_data_i[{w_byteLane, 3'b000} +: 8];
        w_loadHalf = (r_off[1] ^ BIG_ENDIAN) ? ram_data_i[31:16] : ram_data_i[15:0];
        case (r_op)
            OP_LB:        w_loadData = {{24{w_loadByte[7]}}, w_loadByte};
            OP_LBU:       w_loadData = {24'd0, w_loadByte};
            OP_LH:        w_loadData = {{16{w_loadHalf[15]}}, w_loadHalf};
            OP_LHU:       w_loadData = {16'd0, w_loadHalf};
            OP_LW, OP_LL: w_loadData = ram_data_i;
            OP_SC:        w_loadData = 32'd1;
            default:      w_loadData = 32'd0;
        endcase
    end

    // Request FSM; every output is a register so the RAM sees clean strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_op        <= 4'd0;
            r_off       <= 2'd0;
            r_llbit     <= 1'b0;
            r_ready     <= 1'b1;
            r_respValid <= 1'b0;
            r_respRdata <= 32'd0;
            r_respExcp  <= 1'b0;
            r_ce        <= 1'b0;
            r_we        <= 1'b0;
            r_ramAddr   <= 32'd0;
            r_ramData   <= 32'd0;
            r_sel       <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_off   <= req_addr[1:0];
                        r_ready <= 1'b0;
                        if (w_misal || w_sel == 4'b0000 || (req_op == OP_SC && !r_llbit)) begin
                            r_state     <= RESP;
                            r_respValid <= 1'b1;
                            r_respExcp  <= w_misal;
                            r_respRdata <= 32'd0;
                        end else begin
                            r_state   <= ACCESS;
                            r_ce      <= 1'b1;
                            r_we      <= w_isStore;
                            r_ramAddr <= {req_addr[31:2], 2'b00};
                            r_ramData <= w_wdata;
                            r_sel     <= w_sel;
                        end
                    end
                end
                ACCESS: begin
                    r_state     <= RESP;
                    r_ce        <= 1'b0;
                    r_we        <= 1'b0;
                    r_ramAddr   <= 32'd0;
                    r_ramData   <= 32'd0;
                    r_sel       <= 4'd0;
                    r_respValid <= 1'b1;
                    r_respExcp  <= 1'b0;
                    r_respRdata <= w_loadData;
                    if (r_op == OP_LL) begin
                        r_llbit <= 1'b1;
                    end else if (r_op == OP_SC) begin
                        r_llbit <= 1'b0;
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_respValid <= 1'b0;
                    r_ready     <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
            // An external clear overrides any set from an LL finishing this cycle.
            if (llbit_clr) begin
                r_llbit <= 1'b0;
            end
        end
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_respValid;
    assign resp_rdata = r_respRdata;
    assign resp_excp  = r_respExcp;
    assign ram_ce_o   = r_ce;
    assign ram_we_o   = r_we;
    assign ram_addr_o = r_ramAddr;
    assign ram_data_o = r_ramData;
    assign ram_sel_o  = r_sel;
    assign llbit_o    = r_llbit;

endmodule
